wb_commit_rob: RTL and testbench

Dual-issue in-order commit buffer feeding the two write ports of the register file. It allocates entries in program order at issue, accepts out-of-order results from two execution completion ports, and retires up to two completed entries per cycle. Retirement drives the register file's WE3/A3/WD3 and WE3_2/A3_2/WD3_2 ports and the order_change_w flag, so same-register collisions resolve in favour of the younger write.

---
 rtl/wb_commit_rob.sv | 195 +++++++++++++++++++
 tb/tb_wb_commit_rob.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_rob.sv
// Purpose: dual-issue in-order commit buffer driving the two register file write ports.
// Latency: completion at edge N -> write port registered at edge N+1 (one cycle wide).
// Backpressure: alloc_ready drops when fewer than two entries are free; allocs are ignored then.
//
// Ports:
//   clk, reset (async, active-low), flush (sync discard of all unretired entries)
//   alloc_valid0/1, alloc_rd0/1, alloc_we0/1, alloc_lane0/1 -> alloc_ready, alloc_tag0/1
//   cmp_valid_a/b, cmp_tag_a/b, cmp_data_a/b : out-of-order result writeback
//   WE3/A3/WD3 (port 1, lane 0), WE3_2/A3_2/WD3_2 (port 2, lane 1), order_change_w, rob_empty
module wb_commit_rob #(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             alloc_valid0,
    input  logic             alloc_valid1,
    input  logic [4:0]       alloc_rd0,
    input  logic [4:0]       alloc_rd1,
    input  logic             alloc_we0,
    input  logic             alloc_we1,
    input  logic             alloc_lane0,
    input  logic             alloc_lane1,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag0,
    output logic [TAG_W-1:0] alloc_tag1,
    input  logic             cmp_valid_a,
    input  logic             cmp_valid_b,
    input  logic [TAG_W-1:0] cmp_tag_a,
    input  logic [TAG_W-1:0] cmp_tag_b,
    input  logic [31:0]      cmp_data_a,
    input  logic [31:0]      cmp_data_b,
    output logic             WE3,
    output logic [4:0]       A3,
    output logic [31:0]      WD3,
    output logic             WE3_2,
    output logic [4:0]       A3_2,
    output logic [31:0]      WD3_2,
    output logic             order_change_w,
    output logic             rob_empty
);

    typedef struct packed {
        logic        vld;
        logic        done;
        logic        we;
        logic        lane;
        logic [4:0]  rd;
        logic [31:0] dat;
    } ent_t;

    localparam logic [TAG_W:0] ALLOC_MAX = (TAG_W+1)'(DEPTH - 2);

    ent_t             ent [DEPTH];
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   count;

    logic [TAG_W-1:0] head1;
    ent_t             e0;
    ent_t             e1;
    logic             acc0;
    logic             acc1;
    logic             ret0;
    logic             ret1;
    logic [TAG_W:0]   n_alloc;
    logic [TAG_W:0]   n_ret;

    logic             nx_we1;
    logic [4:0]       nx_a1;
    logic [31:0]      nx_d1;
    logic             nx_we2;
    logic [4:0]       nx_a2;
    logic [31:0]      nx_d2;
    logic             nx_oc;

    assign head1       = head + TAG_W'(1);
    assign e0          = ent[head];
    assign e1          = ent[head1];

    assign alloc_ready = (count <= ALLOC_MAX);
    assign rob_empty   = (count == '0);
    assign alloc_tag0  = tail;
    assign alloc_tag1  = alloc_valid0 ? tail + TAG_W'(1) : tail;

    assign acc0 = alloc_ready && !flush && alloc_valid0;
    assign acc1 = alloc_ready && !flush && alloc_valid1;

    // Retirement looks only at registered done bits; a same-lane pair would
    // collide on one write port, so the younger waits a cycle.
    assign ret0 = !flush && e0.vld && e0.done;
    assign ret1 = ret0 && e1.vld && e1.done && (e1.lane != e0.lane);

    assign n_alloc = (TAG_W+1)'(acc0) + (TAG_W+1)'(acc1);
    assign n_ret   = (TAG_W+1)'(ret0) + (TAG_W+1)'(ret1);

    always_comb begin
        nx_we1 = 1'b0;
        nx_a1  = '0;
        nx_d1  = '0;
        nx_we2 = 1'b0;
        nx_a2  = '0;
        nx_d2  = '0;
        nx_oc  = 1'b0;
        if (ret0) begin
            if (!e0.lane) begin
                nx_we1 = e0.we && (e0.rd != 5'd0);
                nx_a1  = e0.rd;
                nx_d1  = e0.dat;
            end else begin
                nx_we2 = e0.we && (e0.rd != 5'd0);
                nx_a2  = e0.rd;
                nx_d2  = e0.dat;
            end
        end
        if (ret1) begin
            if (!e1.lane) begin
                nx_we1 = e1.we && (e1.rd != 5'd0);
                nx_a1  = e1.rd;
                nx_d1  = e1.dat;
            end else begin
                nx_we2 = e1.we && (e1.rd != 5'd0);
                nx_a2  = e1.rd;
                nx_d2  = e1.dat;
            end
            // Older entry on lane 1 means port 1 holds the younger write.
            nx_oc = e0.lane;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            WE3            <= 1'b0;
            A3             <= '0;
            WD3            <= '0;
            WE3_2          <= 1'b0;
            A3_2           <= '0;
            WD3_2          <= '0;
            order_change_w <= 1'b0;
        end else begin
            WE3            <= nx_we1;
            A3             <= nx_a1;
            WD3            <= nx_d1;
            WE3_2          <= nx_we2;
            A3_2           <= nx_a2;
            WD3_2          <= nx_d2;
            order_change_w <= nx_oc;

            // Port b is written last so it wins a tag collision.
            if (cmp_valid_a && ent[cmp_tag_a].vld) begin
                ent[cmp_tag_a].done <= 1'b1;
                ent[cmp_tag_a].dat  <= cmp_data_a;
            end
            if (cmp_valid_b && ent[cmp_tag_b].vld) begin
                ent[cmp_tag_b].done <= 1'b1;
                ent[cmp_tag_b].dat  <= cmp_data_b;
            end

            if (ret0) ent[head].vld  <= 1'b0;
            if (ret1) ent[head1].vld <= 1'b0;

            if (acc0) begin
                ent[alloc_tag0].vld  <= 1'b1;
                ent[alloc_tag0].done <= 1'b0;
                ent[alloc_tag0].we   <= alloc_we0;
                ent[alloc_tag0].lane <= alloc_lane0;
                ent[alloc_tag0].rd   <= alloc_rd0;
            end
            if (acc1) begin
                ent[alloc_tag1].vld  <= 1'b1;
                ent[alloc_tag1].done <= 1'b0;
                ent[alloc_tag1].we   <= alloc_we1;
                ent[alloc_tag1].lane <= alloc_lane1;
                ent[alloc_tag1].rd   <= alloc_rd1;
            end

            head  <= head + TAG_W'(n_ret);
            tail  <= tail + TAG_W'(n_alloc);
            count <= count + n_alloc - n_ret;

            if (flush) begin
                for (int i = 0; i < DEPTH; i++) ent[i].vld <= 1'b0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_commit_rob.sv
// Purpose: directed self-checking bench for wb_commit_rob.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: exercises the full boundary, wrap-around, flush and mid-run reset.
module tb_wb_commit_rob;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        alloc_valid0, alloc_valid1;
    logic [4:0]  alloc_rd0, alloc_rd1;
    logic        alloc_we0, alloc_we1;
    logic        alloc_lane0, alloc_lane1;
    logic        alloc_ready;
    logic [2:0]  alloc_tag0, alloc_tag1;
    logic        cmp_valid_a, cmp_valid_b;
    logic [2:0]  cmp_tag_a, cmp_tag_b;
    logic [31:0] cmp_data_a, cmp_data_b;
    logic        WE3, WE3_2;
    logic [4:0]  A3, A3_2;
    logic [31:0] WD3, WD3_2;
    logic        order_change_w;
    logic        rob_empty;

    int total = 0;
    int bad   = 0;

    wb_commit_rob #(.DEPTH(8), .TAG_W(3)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .alloc_valid0(alloc_valid0), .alloc_valid1(alloc_valid1),
        .alloc_rd0(alloc_rd0), .alloc_rd1(alloc_rd1),
        .alloc_we0(alloc_we0), .alloc_we1(alloc_we1),
        .alloc_lane0(alloc_lane0), .alloc_lane1(alloc_lane1),
        .alloc_ready(alloc_ready), .alloc_tag0(alloc_tag0), .alloc_tag1(alloc_tag1),
        .cmp_valid_a(cmp_valid_a), .cmp_valid_b(cmp_valid_b),
        .cmp_tag_a(cmp_tag_a), .cmp_tag_b(cmp_tag_b),
        .cmp_data_a(cmp_data_a), .cmp_data_b(cmp_data_b),
        .WE3(WE3), .A3(A3), .WD3(WD3),
        .WE3_2(WE3_2), .A3_2(A3_2), .WD3_2(WD3_2),
        .order_change_w(order_change_w), .rob_empty(rob_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0;
        alloc_valid0 = 0; alloc_valid1 = 0;
        alloc_rd0 = 0; alloc_rd1 = 0;
        alloc_we0 = 0; alloc_we1 = 0;
        alloc_lane0 = 0; alloc_lane1 = 0;
        cmp_valid_a = 0; cmp_valid_b = 0;
        cmp_tag_a = 0; cmp_tag_b = 0;
        cmp_data_a = 0; cmp_data_b = 0;
    endtask

    task automatic alloc(input logic v0, input logic [4:0] rd0, input logic we0, input logic l0,
                         input logic v1, input logic [4:0] rd1, input logic we1, input logic l1);
        alloc_valid0 = v0; alloc_rd0 = rd0; alloc_we0 = we0; alloc_lane0 = l0;
        alloc_valid1 = v1; alloc_rd1 = rd1; alloc_we1 = we1; alloc_lane1 = l1;
        tick();
        alloc_valid0 = 0; alloc_valid1 = 0;
    endtask

    task automatic complete(input logic va, input logic [2:0] ta, input logic [31:0] da,
                            input logic vb, input logic [2:0] tb, input logic [31:0] db);
        cmp_valid_a = va; cmp_tag_a = ta; cmp_data_a = da;
        cmp_valid_b = vb; cmp_tag_b = tb; cmp_data_b = db;
        tick();
        cmp_valid_a = 0; cmp_valid_b = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        #12;
        check("rst_we3", WE3, 0);
        check("rst_we3_2", WE3_2, 0);
        check("rst_oc", order_change_w, 0);
        check("rst_ready", alloc_ready, 1);
        check("rst_empty", rob_empty, 1);
        check("rst_tag0", alloc_tag0, 0);
        reset = 1;
        tick();

        // Basic pair on separate lanes, completed out of order.
        alloc_valid0 = 1; alloc_valid1 = 1;
        #0;
        check("t1_tag0", alloc_tag0, 0);
        check("t1_tag1", alloc_tag1, 1);
        alloc(1, 5, 1, 0, 1, 6, 1, 1);
        check("t1_not_empty", rob_empty, 0);
        complete(0, 0, 0, 1, 1, 32'h22);
        check("t1_no_early_we", WE3_2, 0);
        complete(1, 0, 32'h11, 0, 0, 0);
        check("t1_we_not_yet", WE3, 0);
        tick();
        check("t1_we3", WE3, 1);
        check("t1_a3", A3, 5);
        check("t1_wd3", WD3, 32'h11);
        check("t1_we3_2", WE3_2, 1);
        check("t1_a3_2", A3_2, 6);
        check("t1_wd3_2", WD3_2, 32'h22);
        check("t1_oc", order_change_w, 0);
        tick();
        check("t1_we3_pulse", WE3, 0);
        check("t1_we3_2_pulse", WE3_2, 0);
        check("t1_empty", rob_empty, 1);

        // Same rd, older on lane 1: port 1 carries the younger write.
        alloc(1, 7, 1, 1, 1, 7, 1, 0);
        complete(1, 2, 32'hA1, 1, 3, 32'hB2);
        tick();
        check("t2_we3", WE3, 1);
        check("t2_we3_2", WE3_2, 1);
        check("t2_a3", A3, 7);
        check("t2_a3_2", A3_2, 7);
        check("t2_wd3", WD3, 32'hB2);
        check("t2_wd3_2", WD3_2, 32'hA1);
        check("t2_oc", order_change_w, 1);
        tick();
        check("t2_oc_clear", order_change_w, 0);

        // Two lane-0 entries: serialised through port 1.
        alloc(1, 8, 1, 0, 1, 9, 1, 0);
        complete(1, 4, 32'h44, 1, 5, 32'h55);
        tick();
        check("t3_we3_a", WE3, 1);
        check("t3_a3_a", A3, 8);
        check("t3_wd3_a", WD3, 32'h44);
        check("t3_we3_2", WE3_2, 0);
        check("t3_oc", order_change_w, 0);
        tick();
        check("t3_we3_b", WE3, 1);
        check("t3_a3_b", A3, 9);
        check("t3_wd3_b", WD3, 32'h55);
        tick();
        check("t3_done", WE3, 0);
        check("t3_empty", rob_empty, 1);

        // Fill to DEPTH-1 across the wrap (head=tail=6).
        alloc(1, 10, 1, 0, 0, 0, 0, 0);
        alloc_valid0 = 1; alloc_valid1 = 1;
        #0;
        check("t4_wrap_tag0", alloc_tag0, 7);
        check("t4_wrap_tag1", alloc_tag1, 0);
        alloc(1, 11, 1, 0, 1, 12, 1, 0);
        alloc(1, 13, 1, 0, 1, 14, 1, 0);
        check("t4_ready_at6", alloc_ready, 1);
        alloc(1, 15, 1, 0, 1, 16, 1, 0);
        check("t4_full_ready", alloc_ready, 0);
        check("t4_tail_tag", alloc_tag0, 5);
        alloc(1, 17, 1, 0, 1, 18, 1, 0);
        check("t4_ignored_tag", alloc_tag0, 5);
        complete(1, 6, 32'h66, 0, 0, 0);
        check("t4_ready_during_retire", alloc_ready, 0);
        tick();
        check("t4_we3", WE3, 1);
        check("t4_a3", A3, 10);
        check("t4_wd3", WD3, 32'h66);
        check("t4_ready_back", alloc_ready, 1);
        flush = 1;
        tick();
        flush = 0;
        check("t4_flush_empty", rob_empty, 1);

        // Flush with three pending, head completed: its retire is suppressed.
        alloc(1, 20, 1, 0, 1, 21, 1, 1);
        alloc(1, 22, 1, 0, 0, 0, 0, 0);
        complete(1, 0, 32'h20, 0, 0, 0);
        flush = 1;
        tick();
        flush = 0;
        check("t5_we3", WE3, 0);
        check("t5_we3_2", WE3_2, 0);
        check("t5_empty", rob_empty, 1);
        check("t5_tag0", alloc_tag0, 0);
        tick();
        check("t5_we3_later", WE3, 0);

        // rd=0 and we=0 entries retire without a write.
        alloc(1, 0, 1, 0, 1, 4, 0, 1);
        complete(1, 0, 32'hD0, 1, 1, 32'hD1);
        check("t6_pending", rob_empty, 0);
        tick();
        check("t6_we3", WE3, 0);
        check("t6_we3_2", WE3_2, 0);
        check("t6_empty", rob_empty, 1);
        check("t6_tag0", alloc_tag0, 2);

        // Reset mid-operation with a retire pending.
        alloc(1, 3, 1, 0, 0, 0, 0, 0);
        complete(1, 2, 32'h33, 0, 0, 0);
        reset = 0;
        #1;
        check("t7_rst_empty", rob_empty, 1);
        check("t7_rst_tag0", alloc_tag0, 0);
        check("t7_rst_ready", alloc_ready, 1);
        tick();
        check("t7_rst_we3", WE3, 0);
        reset = 1;
        tick();
        check("t7_post_we3", WE3, 0);
        check("t7_post_empty", rob_empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
